// File: rtl/delay_sched_pkg.sv
// Shared definitions for the delay_sched sample delay line:
// controller state encoding, minimum delay and the max-legal-delay helper.
package delay_sched_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        RUN    = 2'd1,
        SWITCH = 2'd2
    } state_t;

    localparam int MIN_DELAY = 1;

    // Largest delay that keeps the read address distinct from the write address.
    function automatic int max_delay(input int addr_width);
        return (1 << addr_width) - 1;
    endfunction

endpackage

// File: rtl/delay_sched_ram.sv
// Simple dual-port RAM for the delay line: one write port and one
// registered read port (latency 1), both on the same clock. Contents are
// never cleared; only the read-data register returns to zero on reset.
module delay_sched_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Write port: store the incoming sample.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: registered read, only updated on a read strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= {DATA_WIDTH{1'b0}};
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/delay_sched.sv
// delay_sched: runtime-programmable sample delay line. Delay is counted in
// valid samples; output is suppressed until enough history exists.
// Optional macro DELAY_SCHED_FLUSH_EN: a config accept clears the fill count,
// so output resumes only after delay_cur fresh samples.
module delay_sched
    import delay_sched_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 10,
    parameter int DEFAULT_DELAY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic [ADDR_WIDTH-1:0] delay_cfg,
    input  logic                  delay_cfg_valid,
    output logic                  delay_cfg_ready,
    output logic [ADDR_WIDTH-1:0] delay_cur,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] FILL_MAX  = ADDR_WIDTH'(max_delay(ADDR_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] DLY_MIN   = ADDR_WIDTH'(MIN_DELAY);
    localparam logic [ADDR_WIDTH-1:0] DLY_RESET = ADDR_WIDTH'(DEFAULT_DELAY);
    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_fill_cnt;
    logic [ADDR_WIDTH-1:0] r_delay_cur;
    logic                  r_dout_valid;
    logic                  r_busy;
    logic                  r_cfg_ready;

    state_t                w_state_base;
    state_t                w_state_nxt;
    logic                  w_out_en;
    logic [ADDR_WIDTH-1:0] w_fill_nxt;
    logic                  w_cfg_acc;
    logic                  w_have_hist;
    logic [ADDR_WIDTH-1:0] w_cfg_clamped;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_ram_en;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_cfg_acc     = delay_cfg_valid & r_cfg_ready;
    assign w_have_hist   = (r_fill_cnt >= r_delay_cur);
    assign w_cfg_clamped = (delay_cfg < DLY_MIN) ? DLY_MIN : delay_cfg;
    // Read the sample written delay_cur valid samples ago; never equals r_wr_ptr.
    assign w_rd_addr     = r_wr_ptr - r_delay_cur;
    assign w_ram_en      = din_valid & ~rst;

    delay_sched_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (w_ram_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (din),
        .i_re    (w_ram_en),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    // Next-state and output-enable decode; a config accept overrides to SWITCH.
    always_comb begin
        w_state_base = r_state;
        w_out_en     = 1'b0;
        case (r_state)
            FILL: begin
                w_out_en = w_have_hist;
                if (din_valid && w_have_hist) begin
                    w_state_base = RUN;
                end else begin
                    w_state_base = FILL;
                end
            end
            RUN: begin
                w_out_en     = 1'b1;
                w_state_base = RUN;
            end
            SWITCH: begin
                w_out_en = 1'b0;
                if (w_have_hist) begin
                    w_state_base = RUN;
                end else begin
                    w_state_base = FILL;
                end
            end
            default: begin
                w_out_en     = 1'b0;
                w_state_base = FILL;
            end
        endcase
        if (w_cfg_acc) begin
            w_state_nxt = SWITCH;
        end else begin
            w_state_nxt = w_state_base;
        end
    end

    // Fill-level update: saturating count of written samples.
    always_comb begin
        w_fill_nxt = r_fill_cnt;
`ifdef DELAY_SCHED_FLUSH_EN
        if (w_cfg_acc) begin
            w_fill_nxt = {ADDR_WIDTH{1'b0}};
        end else if (din_valid && (r_fill_cnt != FILL_MAX)) begin
            w_fill_nxt = r_fill_cnt + ONE;
        end else begin
            w_fill_nxt = r_fill_cnt;
        end
`else
        if (din_valid && (r_fill_cnt != FILL_MAX)) begin
            w_fill_nxt = r_fill_cnt + ONE;
        end else begin
            w_fill_nxt = r_fill_cnt;
        end
`endif
    end

    // Controller registers: FSM, pointers, fill level, delay and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FILL;
            r_wr_ptr     <= {ADDR_WIDTH{1'b0}};
            r_fill_cnt   <= {ADDR_WIDTH{1'b0}};
            r_delay_cur  <= DLY_RESET;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b1;
            r_cfg_ready  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fill_cnt   <= w_fill_nxt;
            r_dout_valid <= din_valid & w_out_en;
            r_busy       <= (w_state_nxt != RUN);
            r_cfg_ready  <= (w_state_nxt != SWITCH);
            if (din_valid) begin
                r_wr_ptr <= r_wr_ptr + ONE;
            end
            if (w_cfg_acc) begin
                r_delay_cur <= w_cfg_clamped;
            end
        end
    end

    assign dout            = w_rd_data;
    assign dout_valid      = r_dout_valid;
    assign delay_cfg_ready = r_cfg_ready;
    assign delay_cur       = r_delay_cur;
    assign busy            = r_busy;

endmodule

// File: tb/tb_delay_sched.sv
// Self-checking bench for delay_sched: directed steps with a scoreboard of
// expected delayed samples built from a sample-history model.
module tb_delay_sched;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic [AW-1:0] delay_cfg = '0;
    logic          delay_cfg_valid = 1'b0;
    logic          delay_cfg_ready;
    logic [AW-1:0] delay_cur;
    logic          busy;

    always #5 clk = ~clk;

    delay_sched #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .DEFAULT_DELAY (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .din             (din),
        .din_valid       (din_valid),
        .dout            (dout),
        .dout_valid      (dout_valid),
        .delay_cfg       (delay_cfg),
        .delay_cfg_valid (delay_cfg_valid),
        .delay_cfg_ready (delay_cfg_ready),
        .delay_cur       (delay_cur),
        .busy            (busy)
    );

    int n_checks = 0;
    int n_err    = 0;

    int q_exp[$];   // scoreboard of expected dout values
    int hist[$];    // every sample written since the last reset
    int m_fill  = 0;
    int m_delay = 4;
    int m_state = 0;   // 0 FILL, 1 RUN, 2 SWITCH
    bit m_ready = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; outputs are checked 1 time unit after the edge.
    task automatic step(input bit v, input int d, input bit cv, input int cfg, input bit r);
        bit acc;
        bit expv;
        int nst;
        rst             = r;
        din_valid       = v;
        din             = d;
        delay_cfg_valid = cv;
        delay_cfg       = cfg[AW-1:0];
        expv            = 1'b0;
        if (r) begin
            hist.delete();
            q_exp.delete();
            m_fill  = 0;
            m_delay = 4;
            m_state = 0;
            m_ready = 1'b0;
        end else begin
            acc  = cv && m_ready;
            expv = v && (m_state == 1 || (m_state == 0 && m_fill >= m_delay));
            if (expv) q_exp.push_back(hist[hist.size() - m_delay]);
            if (v) hist.push_back(d);
            nst = m_state;
            case (m_state)
                0: if (v && m_fill >= m_delay) nst = 1;
                2: nst = (m_fill >= m_delay) ? 1 : 0;
                default: nst = m_state;
            endcase
            if (acc) nst = 2;
`ifdef DELAY_SCHED_FLUSH_EN
            if (acc) m_fill = 0;
            else if (v && m_fill < 1023) m_fill++;
`else
            if (v && m_fill < 1023) m_fill++;
`endif
            if (acc) m_delay = (cfg == 0) ? 1 : cfg;
            m_state = nst;
            m_ready = (nst != 2);
        end
        @(posedge clk);
        #1;
        chk("dout_valid", dout_valid, expv);
        if (dout_valid === 1'b1 && q_exp.size() > 0) chk("dout", dout, q_exp.pop_front());
        chk("delay_cur", delay_cur, m_delay);
        chk("busy", busy, (m_state != 1));
        chk("cfg_ready", delay_cfg_ready, m_ready);
        if (r) chk("rst_dout", dout, 0);
    endtask

    initial begin
        // Reset
        step(1'b0, 0, 1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0, 0, 1'b1);
        chk("reset_delay", delay_cur, 4);
        chk("reset_busy", busy, 1);

        // Continuous stream, default delay 4
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, i, 1'b0, 0, 1'b0);
            if (i < 5) chk("fill_no_out", dout_valid, 0);
            if (i == 5) chk("first_busy_low", busy, 0);
            if (i >= 5) chk("lag4", dout, i - 4);
        end

        // Gapped stream: valid every 3rd cycle
        for (int k = 21; k <= 32; k++) begin
            step(1'b1, k, 1'b0, 0, 1'b0);
            chk("gap_lag4", dout, k - 4);
            step(1'b0, 0, 1'b0, 0, 1'b0);
            chk("gap_idle", dout_valid, 0);
            step(1'b0, 0, 1'b0, 0, 1'b0);
        end

        // Grow delay 4 -> 20 after 100 samples
        for (int k = 33; k <= 100; k++) step(1'b1, k, 1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b1, 20, 1'b0);
        chk("sw_delay", delay_cur, 20);
        chk("sw_ready", delay_cfg_ready, 0);
        step(1'b1, 101, 1'b0, 0, 1'b0);
        chk("sw_suppress", dout_valid, 0);
        for (int k = 102; k <= 130; k++) begin
            step(1'b1, k, 1'b0, 0, 1'b0);
`ifdef DELAY_SCHED_FLUSH_EN
            if (k >= 121) chk("d20_dout", dout, k - 20);
            else chk("d20_flush_wait", dout_valid, 0);
`else
            chk("d20_dout", dout, k - 20);
`endif
        end

        // Delay 0 clamps to 1
        step(1'b0, 0, 1'b1, 0, 1'b0);
        chk("clamp_delay", delay_cur, 1);
        step(1'b0, 0, 1'b0, 0, 1'b0);
        for (int k = 131; k <= 140; k++) begin
            step(1'b1, k, 1'b0, 0, 1'b0);
            if (k >= 132) chk("d1_dout", dout, k - 1);
        end

        // Config coincident with a sample; second request held off in SWITCH
        step(1'b1, 141, 1'b1, 8, 1'b0);
        chk("coinc_old_delay", dout, 140);
        chk("coinc_new_delay", delay_cur, 8);
        step(1'b1, 142, 1'b1, 6, 1'b0);
        chk("held_delay", delay_cur, 8);
        step(1'b0, 0, 1'b1, 6, 1'b0);
        chk("second_accept", delay_cur, 6);
        step(1'b0, 0, 1'b0, 0, 1'b0);
        for (int k = 143; k <= 170; k++) step(1'b1, k, 1'b0, 0, 1'b0);

        // Maximum delay across several pointer wraps
        step(1'b0, 0, 1'b1, 1023, 1'b0);
        chk("max_delay", delay_cur, 1023);
        step(1'b0, 0, 1'b0, 0, 1'b0);
        for (int k = 171; k <= 3170; k++) begin
            step(1'b1, k, 1'b0, 0, 1'b0);
`ifdef DELAY_SCHED_FLUSH_EN
            if (k >= 1194) chk("wrap_dout", dout, k - 1023);
`else
            if (k >= 1024) chk("wrap_dout", dout, k - 1023);
`endif
        end

        // Reset during SWITCH
        step(1'b0, 0, 1'b1, 5, 1'b0);
        step(1'b1, 9999, 1'b0, 0, 1'b1);
        chk("rst_sw_valid", dout_valid, 0);
        chk("rst_sw_delay", delay_cur, 4);
        for (int k = 501; k <= 506; k++) begin
            step(1'b1, k, 1'b0, 0, 1'b0);
            if (k >= 505) chk("post_rst_dout", dout, k - 4);
        end

        // Reset mid-stream drops the in-flight output
        step(1'b1, 600, 1'b0, 0, 1'b1);
        chk("rst_run_valid", dout_valid, 0);
        for (int k = 701; k <= 706; k++) begin
            step(1'b1, k, 1'b0, 0, 1'b0);
            if (k >= 705) chk("post_rst2_dout", dout, k - 4);
        end
        step(1'b0, 0, 1'b0, 0, 1'b0);

        chk("scoreboard_empty", q_exp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/delay_sched.md
Name: delay_sched

Overview:
- Runtime-programmable sample delay line: a circular buffer in block RAM, plus a controller that sequences delay changes.
- Counts delay in valid samples, not clock cycles, so it tolerates gapped input streams.
- Tracks buffer fill level and suppresses output until enough history exists for the active delay.
- Sits in DSP chains where fixed-depth shift-register delays are too costly or must be retuned at run time (e.g. channel alignment).

Parameters:
- DATA_WIDTH, 32, sample width in bits.
- ADDR_WIDTH, 10, RAM address width; buffer depth 2^ADDR_WIDTH; legal delays 1..2^ADDR_WIDTH-1.
- DEFAULT_DELAY, 4, active delay after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- din  in  DATA_WIDTH  input sample.
- din_valid  in  1  input sample strobe.
- dout  out  DATA_WIDTH  delayed sample.
- dout_valid  out  1  output strobe.
- delay_cfg  in  ADDR_WIDTH  requested delay in samples.
- delay_cfg_valid  in  1  config request.
- delay_cfg_ready  out  1  config accept (handshake: transfer when valid&ready).
- delay_cur  out  ADDR_WIDTH  active delay.
- busy  out  1  high when not in RUN.

Behaviour:
Interface:
- One clock `clk`; reset `rst` is synchronous and active-high.

Reset:
- dout=0, dout_valid=0, delay_cur=DEFAULT_DELAY, wr_ptr=0, fill_cnt=0, state=FILL, busy=1, delay_cfg_ready=0 during rst.
- RAM contents are not cleared.

Datapath:
- On din_valid: write din at wr_ptr; wr_ptr increments, wrapping modulo 2^ADDR_WIDTH.
- The same cycle reads address wr_ptr-delay_cur (modulo 2^ADDR_WIDTH).
- Latency: dout/dout_valid are registered and appear 1 cycle after the din_valid that triggered them.
- dout equals the din written delay_cur valid samples earlier.
- fill_cnt increments on each din_valid and saturates at 2^ADDR_WIDTH-1.

State machine:
- FILL: dout_valid=0. Go to RUN on the first din_valid where fill_cnt >= delay_cur, i.e. output appears on the (delay_cur+1)-th input.
- RUN: dout_valid = registered din_valid.
- SWITCH: exactly 1 cycle after a config accept. delay_cur is already updated; any din in this cycle is written but its output is suppressed. Exit to RUN if fill_cnt >= delay_cur, else FILL.

Config handshake:
- delay_cfg_ready=1 in FILL and RUN, 0 in SWITCH and during rst.
- Accepted value 0 is clamped to 1.

Boundary conditions:
- din_valid in the same cycle as a cfg accept: sample is written and output with the OLD delay/state; new delay applies from the next cycle.
- Back-to-back cfg requests: the second stalls for the SWITCH cycle.
- Pointer wrap is transparent.
- rst mid-stream or mid-SWITCH returns to reset values on the next edge; any in-flight dout_valid is dropped.
- Max delay 2^ADDR_WIDTH-1 keeps the read address distinct from the write address (no read-during-write hazard).

Optional Feature:
- Macro: DELAY_SCHED_FLUSH_EN.
- Defined: a cfg accept also clears fill_cnt to 0, so SWITCH always exits to FILL and output resumes only after delay_cur fresh samples (no stale/mixed history).
- Undefined: fill_cnt is retained; when shrinking the delay, or growing it within existing history, output resumes after the single SWITCH cycle.

Decomposition:
- Package delay_sched_pkg holds:
  - state encoding (FILL=2'd0, RUN=2'd1, SWITCH=2'd2);
  - the MIN_DELAY=1 constant;
  - a helper for max legal delay from ADDR_WIDTH.
- One sub-module, delay_sched_ram: simple dual-port RAM, 1 write port, 1 registered read port, read latency 1, same clk.
- Controller (pointers, fill_cnt, FSM, handshake) lives in the top.

Test Plan:
- Reset, then din_valid continuously with din=1,2,3...: first dout_valid the cycle after din=5 is presented, with dout=1; then dout=din-4 every cycle; busy falls with the first dout_valid.
- Gapped input (din_valid every 3rd cycle), delay 4: outputs still lag by 4 samples (dout=n-4); dout_valid only the cycle after each din_valid.
- In RUN after 100 samples, cfg 4->20 (non-flush): 1 SWITCH cycle with dout_valid=0 and cfg_ready=0, then dout=din-20 immediately. With DELAY_SCHED_FLUSH_EN: no output until 20 new samples, then dout=din-20.
- cfg delay=0 accepted -> delay_cur=1, dout=previous sample. cfg 1023 with ADDR_WIDTH=10 -> correct across pointer wrap after 3000 samples.
- cfg accept coincident with din_valid: that sample's output uses the old delay. Second cfg in the SWITCH cycle is held off (cfg_ready=0) and accepted the next cycle.
- Assert rst mid-SWITCH and mid-stream: next cycle dout_valid=0, delay_cur=4, state FILL; output resumes after 4 new samples.
